// File: rtl/vec_pkg.sv
// Shared constants, FSM state encoding and op-kind codes for the vector MAC unit.
package vec_pkg;
    localparam int DATA_W = 32;
    localparam int ACC_W  = 2 * DATA_W + 2;
    localparam int LANES  = 4;
    localparam int IDX_W  = $clog2(LANES) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic OP_LEN = 1'b1;
    localparam logic OP_IP  = 1'b0;

    function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [2*DATA_W-1:0] p);
        return {{(ACC_W - 2 * DATA_W){p[2*DATA_W-1]}}, p};
    endfunction
endpackage

// File: rtl/vec_mul_s.sv
// Combinational full-precision signed DATA_W x DATA_W multiplier.
module vec_mul_s
    import vec_pkg::*;
(
    input  logic signed [DATA_W-1:0]   a,
    input  logic signed [DATA_W-1:0]   b,
    output logic signed [2*DATA_W-1:0] p
);
    logic signed [2*DATA_W-1:0] a_ext;
    logic signed [2*DATA_W-1:0] b_ext;

    assign a_ext = {{DATA_W{a[DATA_W-1]}}, a};
    assign b_ext = {{DATA_W{b[DATA_W-1]}}, b};
    assign p     = a_ext * b_ext;
endmodule

// File: rtl/vec_mac_unit.sv
// Sequential squared-length / inner-product unit: one lane per cycle through a
// shared multiplier, result held in a valid/ready output register.
module vec_mac_unit
    import vec_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     begin_l,
    input  logic                     begin_ip,
    input  logic signed [DATA_W-1:0] x1,
    input  logic signed [DATA_W-1:0] y1,
    input  logic signed [DATA_W-1:0] z1,
    input  logic signed [DATA_W-1:0] w1,
    input  logic signed [DATA_W-1:0] x2,
    input  logic signed [DATA_W-1:0] y2,
    input  logic signed [DATA_W-1:0] z2,
    input  logic signed [DATA_W-1:0] w2,
    output logic signed [ACC_W-1:0]  result,
    output logic                     result_is_len,
    output logic                     result_valid,
    input  logic                     result_ready,
    output logic                     busy,
    output logic                     overrun
);
    state_e                    state_q, state_d;
    logic                      begin_l_q, begin_ip_q;
    logic                      start_l, start_ip, start_any, capture;
    logic signed [DATA_W-1:0]  a_in [LANES];
    logic signed [DATA_W-1:0]  b_in [LANES];
    logic signed [DATA_W-1:0]  a_q  [LANES];
    logic signed [DATA_W-1:0]  a_d  [LANES];
    logic signed [DATA_W-1:0]  b_q  [LANES];
    logic signed [DATA_W-1:0]  b_d  [LANES];
    logic signed [ACC_W-1:0]   acc_q, acc_d, result_q, result_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic                      kind_q, kind_d, is_len_q, is_len_d;
    logic                      valid_q, valid_d, overrun_q, overrun_d;
    logic [IDX_W-2:0]          lane;
    logic signed [DATA_W-1:0]  mul_a, mul_b;
    logic signed [2*DATA_W-1:0] prod;

    assign a_in[0] = x1;
    assign a_in[1] = y1;
    assign a_in[2] = z1;
    assign a_in[3] = w1;
    assign b_in[0] = x2;
    assign b_in[1] = y2;
    assign b_in[2] = z2;
    assign b_in[3] = w2;

    assign start_l   = begin_l & ~begin_l_q;
    assign start_ip  = begin_ip & ~begin_ip_q;
    assign start_any = start_l | start_ip;
    assign capture   = (state_q == S_IDLE) && start_any;

    // Local operand copies so the FSM may change its outputs mid-operation.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            always_comb begin
                a_d[gi] = capture ? a_in[gi] : a_q[gi];
                b_d[gi] = capture ? b_in[gi] : b_q[gi];
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    a_q[gi] <= '0;
                    b_q[gi] <= '0;
                end else begin
                    a_q[gi] <= a_d[gi];
                    b_q[gi] <= b_d[gi];
                end
            end
        end
    endgenerate

    assign lane  = idx_q[IDX_W-2:0];
    assign mul_a = a_q[lane];
    assign mul_b = (kind_q == OP_LEN) ? a_q[lane] : b_q[lane];

    vec_mul_s u_mul (
        .a (mul_a),
        .b (mul_b),
        .p (prod)
    );

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        kind_d    = kind_q;
        result_d  = result_q;
        is_len_d  = is_len_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;

        if (state_q != S_IDLE && start_any) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start_any) begin
                    kind_d  = start_ip ? OP_IP : OP_LEN;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                // One extra pass after the last lane moves the sum into the output register.
                if (idx_q == IDX_W'(LANES)) begin
                    result_d = acc_q;
                    is_len_d = kind_q;
                    valid_d  = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    acc_d = acc_q + sext_prod(prod);
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                if (valid_q && result_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            begin_l_q  <= 1'b0;
            begin_ip_q <= 1'b0;
            acc_q      <= '0;
            idx_q      <= '0;
            kind_q     <= OP_IP;
            result_q   <= '0;
            is_len_q   <= 1'b0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            begin_l_q  <= begin_l;
            begin_ip_q <= begin_ip;
            acc_q      <= acc_d;
            idx_q      <= idx_d;
            kind_q     <= kind_d;
            result_q   <= result_d;
            is_len_q   <= is_len_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign result        = result_q;
    assign result_is_len = is_len_q;
    assign result_valid  = valid_q;
    assign overrun       = overrun_q;
    assign busy          = (state_q != S_IDLE);
endmodule

// File: tb/tb_vec_mac_unit.sv
// Directed bench for vec_mac_unit with an expected-result queue.
module tb_vec_mac_unit;
    import vec_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, begin_l, begin_ip, result_ready;
    logic signed [DATA_W-1:0] va [LANES];
    logic signed [DATA_W-1:0] vb [LANES];
    logic signed [DATA_W-1:0] x1, y1, z1, w1, x2, y2, z2, w2;
    logic signed [ACC_W-1:0]  result;
    logic result_is_len, result_valid, busy, overrun;

    assign x1 = va[0];
    assign y1 = va[1];
    assign z1 = va[2];
    assign w1 = va[3];
    assign x2 = vb[0];
    assign y2 = vb[1];
    assign z2 = vb[2];
    assign w2 = vb[3];

    vec_mac_unit dut (
        .clock(clk), .reset(reset), .begin_l(begin_l), .begin_ip(begin_ip),
        .x1(x1), .y1(y1), .z1(z1), .w1(w1), .x2(x2), .y2(y2), .z2(z2), .w2(w2),
        .result(result), .result_is_len(result_is_len), .result_valid(result_valid),
        .result_ready(result_ready), .busy(busy), .overrun(overrun)
    );

    typedef struct {
        logic [ACC_W-1:0] res;
        logic             is_len;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [ACC_W-1:0] got, input logic [ACC_W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic set_ops(input int a0, input int a1, input int a2, input int a3,
                           input int b0, input int b1, input int b2, input int b3);
        va[0] = a0; va[1] = a1; va[2] = a2; va[3] = a3;
        vb[0] = b0; vb[1] = b1; vb[2] = b2; vb[3] = b3;
    endtask

    function automatic logic [ACC_W-1:0] model(input bit ip);
        logic signed [ACC_W-1:0] s, ea, eb;
        s = '0;
        for (int i = 0; i < LANES; i++) begin
            ea = va[i];
            eb = ip ? vb[i] : va[i];
            s  = s + ea * eb;
        end
        return s;
    endfunction

    task automatic start(input bit ip, input bit push, input logic [ACC_W-1:0] exp);
        if (push) sb.push_back('{exp, !ip});
        if (ip) begin_ip = 1'b1;
        else    begin_l  = 1'b1;
        tick();
        begin_ip = 1'b0;
        begin_l  = 1'b0;
    endtask

    // Wait for valid, hold ready low for 'hold' cycles, then accept (optionally with a colliding start).
    task automatic collect(input string tag, input int hold, input bit clash);
        exp_t e;
        int   n;
        e = '{default: '0};
        n = 0;
        while (!result_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, result_valid, 1);
        chk({tag, "_sb"}, sb.size() > 0, 1);
        if (sb.size() > 0) e = sb.pop_front();
        for (int i = 0; i < hold; i++) begin
            chk({tag, "_hold_res"}, result, e.res);
            chk({tag, "_hold_vld"}, result_valid, 1);
            tick();
        end
        chk({tag, "_res"}, result, e.res);
        chk({tag, "_len"}, result_is_len, e.is_len);
        $display("TXN %s result=%0d is_len=%0b", tag, result, result_is_len);
        result_ready = 1'b1;
        if (clash) begin_l = 1'b1;
        tick();
        result_ready = 1'b0;
        begin_l      = 1'b0;
        chk({tag, "_drop"}, result_valid, 0);
        chk({tag, "_keep"}, result, e.res);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        reset = 1'b1; begin_l = 1'b0; begin_ip = 1'b0; result_ready = 1'b0;
        set_ops(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk("rst_res", result, 0);
        chk("rst_vld", result_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_len", result_is_len, 0);
        reset = 1'b0;
        tick();

        // Length with a long begin level and ready already high: one pulse at E+5.
        set_ops(3, 4, 0, 0, 0, 0, 0, 0);
        sb.push_back('{66'd25, 1'b1});
        begin_l = 1'b1;
        result_ready = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c <= 5) chk("len_early", result_valid, 0);
            if (c == 6) begin
                chk("len_vld", result_valid, 1);
                e = sb.pop_front();
                chk("len_res", result, e.res);
                chk("len_kind", result_is_len, e.is_len);
                $display("TXN len result=%0d is_len=%0b", result, result_is_len);
            end
            if (c >= 7) begin
                chk("len_pulse", result_valid, 0);
                chk("len_noretrig", busy, 0);
            end
        end
        begin_l = 1'b0;
        result_ready = 1'b0;
        tick();

        set_ops(1, 2, 3, 4, 5, 6, 7, 8);
        start(1'b1, 1'b1, 66'd70);
        collect("ip", 8, 1'b0);

        set_ops(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
        start(1'b1, 1'b1, 66'h1_0000_0000_0000_0000);
        collect("ext_min", 0, 1'b0);

        set_ops(-1, 1, 0, 0, 1, 1, 0, 0);
        start(1'b1, 1'b1, 66'd0);
        collect("ext_zero", 0, 1'b0);

        set_ops(1, 2, 3, 4, 2, 2, 2, 2);
        sb.push_back('{66'd20, 1'b0});
        begin_l = 1'b1;
        begin_ip = 1'b1;
        tick();
        begin_l = 1'b0;
        begin_ip = 1'b0;
        collect("both", 0, 1'b0);
        chk("both_ovr", overrun, 0);

        set_ops(5, -6, 7, -8, 1, 2, 3, 4);
        start(1'b1, 1'b1, -66'sd18);
        tick();
        begin_l = 1'b1;
        set_ops(99, 99, 99, 99, 99, 99, 99, 99);
        tick();
        begin_l = 1'b0;
        chk("mac_ovr", overrun, 1);
        chk("mac_busy", busy, 1);
        collect("drop", 2, 1'b0);
        chk("ovr_sticky", overrun, 1);

        // Reset lands on the lane-2 accumulate edge.
        set_ops(9, 9, 9, 9, 0, 0, 0, 0);
        start(1'b0, 1'b0, 66'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_res", result, 0);
        chk("abort_vld", result_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ovr", overrun, 0);
        chk("abort_len", result_is_len, 0);
        for (int i = 0; i < 8; i++) tick();
        chk("abort_quiet", result_valid, 0);
        set_ops(2, 3, 4, 5, 0, 0, 0, 0);
        start(1'b0, 1'b1, 66'd54);
        collect("post_rst", 0, 1'b0);

        // Second edge on the cycle after accept, then a start exactly on an accept edge.
        set_ops(1, 1, 1, 1, -3, 4, -5, 6);
        start(1'b1, 1'b1, 66'd2);
        collect("b2b_1", 0, 1'b0);
        set_ops(7, 1, 0, 0, 7, -1, 0, 0);
        start(1'b1, 1'b1, 66'd48);
        chk("b2b_busy", busy, 1);
        chk("b2b_ovr", overrun, 0);
        collect("b2b_2", 1, 1'b1);
        chk("acc_edge_ovr", overrun, 1);
        chk("acc_edge_busy", busy, 0);
        tick();
        chk("acc_edge_idle", busy, 0);

        for (int k = 0; k < 4; k++) begin
            bit ip;
            ip = k[0];
            set_ops($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
            start(ip, 1'b1, model(ip));
            collect("rand", $urandom_range(0, 3), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
